// File: rtl/gp_reg_banked.sv
// gp_reg_banked: 64-bit banked register file with bypassed combinational read
// ports, a hard-wired zero region and a sequencer that exchanges the banked
// GPRs with their shadow copies one entry per cycle.

// Read lane: raw array decode, overridden by the bypass value when this port
// reads the register being written this cycle.
module gp_reg_banked_rd_lane (
  input  logic [6:0]        rd_id,
  input  logic [6:0]        wr_id,
  input  logic              byp_en,
  input  logic [63:0]       byp_val,
  input  logic [63:0][31:0] lo,
  input  logic [63:0][31:0] hi,
  input  logic [7:0][63:0]  ctrl,
  output logic [63:0]       rd_data
);
  logic [63:0] raw;

  // Region decode of the raw array contents
  always_comb begin
    raw = '0;
    if (!rd_id[6])                  raw = {hi[rd_id[5:0]], lo[rd_id[5:0]]};
    else if (rd_id[6:3] == 4'b1010) raw = ctrl[rd_id[2:0]];
    else if (rd_id[6:3] == 4'b1011) raw = '0;  // 0x58-0x5F incl. ZZR
    else                            raw = {32'h0, hi[rd_id[5:0]]};
  end

  // Same-cycle write forwarding
  always_comb begin
    rd_data = raw;
    if (byp_en && (rd_id == wr_id)) rd_data = byp_val;
  end
endmodule

module gp_reg_banked #(
  parameter int NRD   = 3,
  parameter int NBANK = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wr_en,
  input  logic                wr_qw,
  input  logic [6:0]          wr_id,
  input  logic [63:0]         wr_data,
  input  logic [7*NRD-1:0]    rd_id,
  output logic [64*NRD-1:0]   rd_data,
  input  logic                bank_req,
  output logic                bank_cur,
  output logic                swap_busy,
  output logic                wr_drop
);
  localparam int KW = (NBANK > 1) ? $clog2(NBANK) : 1;

  typedef enum logic {S_IDLE, S_SWAP} state_t;

  // Only ctrl entries 0..7 are reachable (0x50-0x57); the rest of the
  // control space has no write path, so it is not stored.
  logic [63:0][31:0]       lo_q, lo_d, hi_q, hi_d;
  logic [7:0][63:0]        ctrl_q, ctrl_d;
  logic [NBANK-1:0][63:0]  sh_q, sh_d;
  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic                    bank_q, bank_d;
  logic                    drop_q, drop_d;

  logic        busy, wr_ok, wr_zz;
  logic [5:0]  kg;
  logic [63:0] byp_val;

  assign busy  = (state_q == S_SWAP);
  assign wr_ok = wr_en && !busy;
  assign wr_zz = (wr_id[6:3] == 4'b1011);
  assign kg    = 6'(k_q);

  // Value a read of wr_id returns after this cycle's write lands
  always_comb begin
    byp_val = '0;
    if (!wr_id[6])
      byp_val = wr_qw ? wr_data : {hi_q[wr_id[5:0]], wr_data[31:0]};
    else if (wr_id[6:3] == 4'b1010)
      byp_val = wr_qw ? wr_data : {ctrl_q[wr_id[2:0]][63:32], wr_data[31:0]};
    else if (wr_zz)
      byp_val = '0;
    else
      byp_val = {32'h0, wr_qw ? wr_data[63:32] : wr_data[31:0]};
  end

  // Next state: array writes, drop pulse, and the swap sequencer
  always_comb begin
    lo_d    = lo_q;
    hi_d    = hi_q;
    ctrl_d  = ctrl_q;
    sh_d    = sh_q;
    state_d = state_q;
    k_d     = k_q;
    bank_d  = bank_q;
    drop_d  = wr_en && busy && !wr_zz;

    if (wr_ok) begin
      if (!wr_id[6]) begin
        lo_d[wr_id[5:0]] = wr_data[31:0];
        if (wr_qw) hi_d[wr_id[5:0]] = wr_data[63:32];
      end else if (wr_id[6:3] == 4'b1010) begin
        ctrl_d[wr_id[2:0]][31:0] = wr_data[31:0];
        if (wr_qw) ctrl_d[wr_id[2:0]][63:32] = wr_data[63:32];
      end else if (!wr_zz) begin
        // Upper-half alias window: 32-bit writes land in hi
        if (wr_qw) begin
          lo_d[wr_id[5:0]] = wr_data[31:0];
          hi_d[wr_id[5:0]] = wr_data[63:32];
        end else begin
          hi_d[wr_id[5:0]] = wr_data[31:0];
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bank_req != bank_q) begin
          state_d = S_SWAP;
          k_d     = '0;
        end
      end
      S_SWAP: begin
        lo_d[kg] = sh_q[k_q][31:0];
        hi_d[kg] = sh_q[k_q][63:32];
        sh_d[k_q] = {hi_q[kg], lo_q[kg]};
        if (k_q == KW'(NBANK - 1)) begin
          state_d = S_IDLE;
          bank_d  = ~bank_q;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any swap in progress
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lo_q    <= '0;
      hi_q    <= '0;
      ctrl_q  <= '0;
      sh_q    <= '0;
      state_q <= S_IDLE;
      k_q     <= '0;
      bank_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      ctrl_q  <= ctrl_d;
      sh_q    <= sh_d;
      state_q <= state_d;
      k_q     <= k_d;
      bank_q  <= bank_d;
      drop_q  <= drop_d;
    end
  end

  genvar p;
  generate
    for (p = 0; p < NRD; p++) begin : g_rd
      gp_reg_banked_rd_lane u_lane (
        .rd_id   (rd_id[p*7 +: 7]),
        .wr_id   (wr_id),
        .byp_en  (wr_ok),
        .byp_val (byp_val),
        .lo      (lo_q),
        .hi      (hi_q),
        .ctrl    (ctrl_q),
        .rd_data (rd_data[p*64 +: 64])
      );
    end
  endgenerate

  assign bank_cur  = bank_q;
  assign swap_busy = busy;
  assign wr_drop   = drop_q;
endmodule

// File: tb/tb_gp_reg_banked.sv
// Scoreboard bench for gp_reg_banked: expectations are queued as stimulus is
// driven and checked against the DUT on the falling edge.
module tb_gp_reg_banked;
  localparam int NRD = 3, NBANK = 8;
  localparam int K_CUR = NRD, K_BUSY = NRD + 1, K_DROP = NRD + 2;

  logic               clk = 1'b0, rstn = 1'b0;
  logic               wr_en = 1'b0, wr_qw = 1'b0;
  logic [6:0]         wr_id = '0;
  logic [63:0]        wr_data = '0;
  logic [7*NRD-1:0]   rd_id = '0;
  logic [64*NRD-1:0]  rd_data;
  logic               bank_req = 1'b0, bank_cur, swap_busy, wr_drop;

  gp_reg_banked #(.NRD(NRD), .NBANK(NBANK)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_qw(wr_qw), .wr_id(wr_id),
    .wr_data(wr_data), .rd_id(rd_id), .rd_data(rd_data), .bank_req(bank_req),
    .bank_cur(bank_cur), .swap_busy(swap_busy), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {string tag; int kind; logic [63:0] val;} exp_t;
  exp_t sbq[$];

  task automatic push(input string tag, input int kind, input logic [63:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.val = val;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [63:0] obs;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.kind < NRD)          obs = rd_data[e.kind*64 +: 64];
      else if (e.kind == K_CUR)  obs = {63'd0, bank_cur};
      else if (e.kind == K_BUSY) obs = {63'd0, swap_busy};
      else                       obs = {63'd0, wr_drop};
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic setrd(input int p, input logic [6:0] id);
    rd_id[p*7 +: 7] = id;
  endtask

  task automatic wr(input logic [6:0] id, input logic qw, input logic [63:0] d);
    wr_en = 1'b1; wr_qw = qw; wr_id = id; wr_data = d;
  endtask

  task automatic nowr();
    wr_en = 1'b0; wr_qw = 1'b0;
  endtask

  // Read R0..R7 over three cycles; base=1 expects Rk=k+1, base=0 expects 0
  task automatic rd8(input string tag, input int base);
    for (int g = 0; g < 3; g++) begin
      for (int p = 0; p < NRD; p++) begin
        int idx;
        idx = g * NRD + p;
        if (idx < NBANK) begin
          setrd(p, 7'(idx));
          push($sformatf("%s_r%0d", tag, idx), p, (base != 0) ? 64'(idx + 1) : 64'd0);
        end
      end
      cyc();
    end
  endtask

  // Expect busy for NBANK cycles with bank_cur still at old value
  task automatic busy_run(input string tag, input logic cur);
    for (int i = 0; i < NBANK; i++) begin
      push($sformatf("%s_busy%0d", tag, i), K_BUSY, 64'd1);
      push($sformatf("%s_cur%0d", tag, i), K_CUR, {63'd0, cur});
      cyc();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset state
    setrd(0, 7'h00); setrd(1, 7'h20); setrd(2, 7'h5F);
    push("rst_p0", 0, 0); push("rst_p1", 1, 0); push("rst_p2", 2, 0);
    push("rst_cur", K_CUR, 0); push("rst_busy", K_BUSY, 0); push("rst_drop", K_DROP, 0);
    cyc();

    // 64-bit write with bypass; alias read not forwarded
    wr(7'h03, 1'b1, 64'h0123_4567_89AB_CDEF);
    setrd(0, 7'h03); setrd(1, 7'h43);
    push("qw_byp", 0, 64'h0123_4567_89AB_CDEF);
    push("qw_alias_old", 1, 64'h0);
    cyc();
    nowr();
    push("qw_arr", 0, 64'h0123_4567_89AB_CDEF);
    push("qw_alias", 1, 64'h0000_0000_0123_4567);
    cyc();
    wr(7'h03, 1'b0, 64'h0000_0000_FFFF_0000);
    cyc();
    nowr();
    push("dw_lo", 0, 64'h0123_4567_FFFF_0000);
    cyc();

    // Bypass with old hi; ZZR on another port
    wr(7'h05, 1'b1, 64'hDEAD_BEEF_1111_1111);
    cyc();
    wr(7'h05, 1'b0, 64'h0000_0000_0000_00AA);
    setrd(0, 7'h05); setrd(1, 7'h45); setrd(2, 7'h5F);
    push("byp_dw", 0, 64'hDEAD_BEEF_0000_00AA);
    push("byp_alias", 1, 64'h0000_0000_DEAD_BEEF);
    push("byp_zzr", 2, 64'h0);
    cyc();
    nowr();
    push("byp_arr", 0, 64'hDEAD_BEEF_0000_00AA);
    cyc();

    // Hi-only alias write
    wr(7'h41, 1'b0, 64'h0000_0000_0000_1234);
    setrd(0, 7'h41); setrd(1, 7'h01);
    push("hi_byp", 0, 64'h0000_0000_0000_1234);
    push("hi_full_old", 1, 64'h0);
    cyc();
    nowr();
    push("hi_full", 1, 64'h0000_1234_0000_0000);
    cyc();

    // Control register halves, ZZR write ignored
    wr(7'h50, 1'b1, 64'h1111_2222_3333_4444);
    setrd(0, 7'h50);
    push("ctl_qw", 0, 64'h1111_2222_3333_4444);
    cyc();
    wr(7'h50, 1'b0, 64'hAAAA_BBBB_5555_6666);
    push("ctl_dw", 0, 64'h1111_2222_5555_6666);
    cyc();
    wr(7'h5F, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    setrd(2, 7'h5F);
    push("zzr_wr", 2, 64'h0);
    push("ctl_arr", 0, 64'h1111_2222_5555_6666);
    cyc();
    wr(7'h09, 1'b1, 64'h99);
    push("zzr_nodrop", K_DROP, 0);
    cyc();

    // Fill R0..R7 and swap out
    for (int k = 0; k < NBANK; k++) begin
      wr(7'(k), 1'b1, 64'(k + 1));
      cyc();
    end
    nowr();
    bank_req = 1'b1;
    push("sw1_pre", K_BUSY, 0);
    cyc();
    for (int i = 0; i < NBANK; i++) begin
      push($sformatf("sw1_busy%0d", i), K_BUSY, 1);
      if (i == 1) wr(7'h09, 1'b1, 64'h5555);
      if (i == 2) begin nowr(); push("drop_pulse", K_DROP, 1); end
      if (i == 3) push("drop_end", K_DROP, 0);
      cyc();
    end
    push("sw1_done", K_BUSY, 0); push("sw1_cur", K_CUR, 1);
    setrd(0, 7'h09);
    push("drop_target", 0, 64'h99);
    cyc();
    rd8("sw1", 0);

    // Swap back
    bank_req = 1'b0;
    push("sw2_pre", K_BUSY, 0);
    cyc();
    busy_run("sw2", 1'b1);
    push("sw2_done", K_BUSY, 0); push("sw2_cur", K_CUR, 0);
    cyc();
    rd8("sw2", 1);

    // Two toggles mid-swap: net unchanged, no second swap
    bank_req = 1'b1;
    cyc();
    for (int i = 0; i < NBANK; i++) begin
      if (i == 1) bank_req = 1'b0;
      if (i == 3) bank_req = 1'b1;
      push($sformatf("dbl_busy%0d", i), K_BUSY, 1);
      cyc();
    end
    push("dbl_done", K_BUSY, 0); push("dbl_cur", K_CUR, 1);
    cyc();
    push("dbl_idle", K_BUSY, 0);
    cyc();
    rd8("dbl", 0);

    // Single toggle mid-swap: second swap after one idle cycle
    bank_req = 1'b0;
    cyc();
    for (int i = 0; i < NBANK; i++) begin
      if (i == 2) bank_req = 1'b1;
      push($sformatf("one_busy%0d", i), K_BUSY, 1);
      cyc();
    end
    push("one_gap", K_BUSY, 0); push("one_gap_cur", K_CUR, 0);
    cyc();
    busy_run("one2", 1'b0);
    push("one2_done", K_BUSY, 0); push("one2_cur", K_CUR, 1);
    cyc();
    rd8("one2", 0);

    // Reset during swap step 3
    bank_req = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) cyc();
    rstn = 1'b0;
    #1;
    setrd(0, 7'h03); setrd(1, 7'h50); setrd(2, 7'h09);
    push("mrst_busy", K_BUSY, 0); push("mrst_cur", K_CUR, 0);
    push("mrst_p0", 0, 0); push("mrst_p1", 1, 0); push("mrst_p2", 2, 0);
    cyc();
    rstn = 1'b1;
    push("mrst_drop", K_DROP, 0);
    rd8("mrst", 0);
    push("mrst_idle", K_BUSY, 0); push("mrst_idle_cur", K_CUR, 0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
